// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART 8N1 transmitter: pops one byte per frame from a registered-read FIFO
// and serialises it LSB first on tx. All outputs come straight from flops.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BitLast = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    rd_en_q, rd_en_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;

        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                // Read data is valid here, one cycle after the pop pulse.
                shift_d   = fifo_dout;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = StStart;
            end
            StStart: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from next state so the flopped values line up with state_q.
        rd_en_d = (state_d == StFetch);
        done_d  = (state_d == StStop) && (clk_cnt_d == CntLast);
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign tx_done    = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small registered-read FIFO model, CLKS_PER_BIT = 4.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       rd_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       force_empty = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [0:15];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int rd_en_cnt = 0;
    int done_cnt = 0;
    int underflow = 0;

    int n_cmp = 0;
    int n_fail = 0;

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // FIFO model: data appears on fifo_dout one cycle after the pop edge.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            rd_en_cnt <= rd_en_cnt + 1;
            if (rd_ptr == wr_ptr) begin
                underflow <= underflow + 1;
            end else begin
                fifo_dout <= mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // Returns with the bench sitting in the first start-bit cycle.
    task automatic wait_start(input string tag, output int gap);
        int found;
        found = 0;
        gap   = 0;
        for (int k = 0; k < 60; k++) begin
            if (tx === 1'b0) begin
                found = 1;
                break;
            end
            gap++;
            tick();
        end
        check({tag, "_start_seen"}, found, 1);
    endtask

    // Checks all 10*CPB frame cycles, then the first idle cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s_tx_b%0d_c%0d", tag, i, c), tx, frame_bit(b, i));
                check($sformatf("%s_done_b%0d_c%0d", tag, i, c), tx_done,
                      (i == 9 && c == CPB - 1) ? 1 : 0);
                check($sformatf("%s_busy_b%0d_c%0d", tag, i, c), busy, 1);
                tick();
            end
        end
        check({tag, "_after_done"}, tx_done, 0);
        check({tag, "_after_busy"}, busy, 0);
        check({tag, "_after_tx"}, tx, 1);
    endtask

    initial begin
        int gap;
        int bad;
        int rd0;
        int done0;

        // 1. reset state, then idle with an empty FIFO
        tick();
        tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_done", tx_done, 0);
        rst    = 1'b0;
        enable = 1'b1;
        bad    = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check("t1_idle_bad_cycles", bad, 0);
        check("t1_rd_en_cnt", rd_en_cnt, 0);

        // 2. single byte 0xA5, pop pulse and 3-cycle latency
        push(8'hA5);
        tick();
        check("t2_fetch_rd_en", fifo_rd_en, 1);
        check("t2_fetch_busy", busy, 1);
        check("t2_fetch_tx", tx, 1);
        tick();
        check("t2_latch_rd_en", fifo_rd_en, 0);
        check("t2_latch_tx", tx, 1);
        tick();
        check_frame(8'hA5, "t2");
        check("t2_rd_en_cnt", rd_en_cnt, 1);
        check("t2_done_cnt", done_cnt, 1);

        // 3. back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        wait_start("t3a", gap);
        check("t3a_gap", gap, 3);
        check_frame(8'h00, "t3a");
        wait_start("t3b", gap);
        check("t3b_gap", gap, 3);
        check_frame(8'hFF, "t3b");
        check("t3_rd_en_cnt", rd_en_cnt, 3);
        check("t3_done_cnt", done_cnt, 3);

        // 4. reset in the 5th data bit of 0x3C; 0x5A follows intact
        push(8'h3C);
        push(8'h5A);
        wait_start("t4a", gap);
        done0 = done_cnt;
        for (int k = 0; k < 5 * CPB; k++) tick();
        check("t4_bit4_tx", tx, 1);
        tick();
        rst = 1'b1;
        tick();
        check("t4_rst_tx", tx, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_done", tx_done, 0);
        rst = 1'b0;
        check("t4_no_done", done_cnt, done0);
        wait_start("t4b", gap);
        check("t4b_gap", gap, 3);
        check_frame(8'h5A, "t4b");
        check("t4_rd_en_cnt", rd_en_cnt, 5);
        check("t4_done_cnt", done_cnt, 4);

        // 5. enable dropped in the start bit of 0x81 with 0x42 queued
        push(8'h81);
        push(8'h42);
        wait_start("t5a", gap);
        enable = 1'b0;
        check_frame(8'h81, "t5a");
        rd0 = rd_en_cnt;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check("t5_hold_bad_cycles", bad, 0);
        check("t5_hold_rd_en_cnt", rd_en_cnt, rd0);
        enable = 1'b1;
        wait_start("t5b", gap);
        check("t5b_gap", gap, 3);
        check_frame(8'h42, "t5b");
        check("t5_rd_en_cnt", rd_en_cnt, 7);

        // 6. fifo_empty rises mid-frame of 0x99; 0x24 waits until empty clears
        push(8'h99);
        push(8'h24);
        wait_start("t6a", gap);
        force_empty = 1'b1;
        check_frame(8'h99, "t6a");
        rd0 = rd_en_cnt;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        check("t6_hold_bad_cycles", bad, 0);
        check("t6_hold_rd_en_cnt", rd_en_cnt, rd0);
        force_empty = 1'b0;
        wait_start("t6b", gap);
        check("t6b_gap", gap, 3);
        check_frame(8'h24, "t6b");
        check("t6_rd_en_cnt", rd_en_cnt, 9);
        check("t6_done_cnt", done_cnt, 8);
        check("underflow_cnt", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
